// File: rtl/out_port_arbiter_pkg.sv
// out_port_arbiter_pkg: shared sizes, FSM encoding and pointer wrap helper for the output-port arbiter
package out_port_arbiter_pkg;
  localparam int N_IN    = 4;
  localparam int DW      = 8;
  localparam int PKT_LEN = 4;
  localparam int N_PORTS = 5;
  localparam int PW      = $clog2(N_IN);
  localparam int CW      = $clog2(PKT_LEN);
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2} state_t;
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N_IN - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/out_port_arbiter_if.sv
// out_port_arbiter_if: FIFO-bank request/data side and output link side of one output port
interface out_port_arbiter_if;
  import out_port_arbiter_pkg::*;
  logic [N_IN-1:0]    req;
  logic [N_IN*DW-1:0] fifo_data;
  logic               out_ready;
  logic [N_IN-1:0]    fifo_rd;
  logic [N_IN-1:0]    grant;
  logic [DW-1:0]      out_data;
  logic               out_valid;
  logic               busy;
  modport master (input req, fifo_data, out_ready, output fifo_rd, grant, out_data, out_valid, busy);
  modport slave (output req, fifo_data, out_ready, input fifo_rd, grant, out_data, out_valid, busy);
endinterface

// File: rtl/out_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick of the first requester at or after ptr_i
module rr_arbiter
  import out_port_arbiter_pkg::*;
(
  input  logic [N_IN-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [N_IN-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);
  logic [PW:0]   sum;
  logic [PW-1:0] p;
  // scan from the farthest offset down so the nearest requester is written last and wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = |req_i;
    sum   = '0;
    p     = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      p   = (sum >= (PW+1)'(N_IN)) ? PW'(sum - (PW+1)'(N_IN)) : PW'(sum);
      if (req_i[p]) begin
        gnt_o    = '0;
        gnt_o[p] = 1'b1;
        idx_o    = p;
      end
    end
  end
endmodule

// File: rtl/out_port_arbiter.sv
// out_port_arbiter: round-robin packet arbiter locking one input FIFO onto the output link per packet
module out_port_arbiter
  import out_port_arbiter_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  out_port_arbiter_if.master bus
);
  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   own_q, own_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] grant_q, grant_d;
  logic            valid_q;
  logic [N_IN-1:0] win;
  logic [PW-1:0]   win_idx;
  logic            any;
  logic            rd;
  rr_arbiter u_rr (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .gnt_o (win),
    .idx_o (win_idx),
    .any_o (any)
  );
  assign rd = (state_q == XFER) && bus.out_ready && bus.req[own_q];
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    own_d    = own_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = XFER;
        grant_d = win;
        own_d   = win_idx;
        cnt_d   = '0;
      end
      XFER: if (rd) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(PKT_LEN - 1)) ? DRAIN : XFER;
      end
      DRAIN: begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = ptr_inc(own_q);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      own_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      own_q    <= own_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      valid_q  <= rd;
    end
  end
  // FIFO output is registered, so the flit shows up the cycle after its strobe
  assign bus.fifo_rd   = rd ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = valid_q ? bus.fifo_data[own_q*DW +: DW] : '0;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_out_port_arbiter.sv
// tb_out_port_arbiter: FIFO-bank model plus flit scoreboard exercising arbitration, stalls and reset
module tb_out_port_arbiter;
  import out_port_arbiter_pkg::*;
  typedef struct {
    logic [DW-1:0]   d;
    logic [N_IN-1:0] g;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  out_port_arbiter_if bus ();
  out_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t            exp_q[$];
  exp_t            e;
  logic [DW-1:0]   mem[N_IN][256];
  logic [7:0]      rp[N_IN];
  logic [7:0]      wp[N_IN];
  logic [N_IN-1:0] en = '0;
  logic [DW-1:0]   seq = '0;
  bit              sb_en = 1'b1;
  int              n_chk = 0;
  int              n_pass = 0;
  int              cnt;
  int              nb;
  int              nr;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask
  task automatic load(input int p, input bit scored);
    for (int k = 0; k < PKT_LEN; k++) begin
      mem[p][wp[p]] = seq;
      if (scored) exp_q.push_back('{seq, N_IN'(1) << p});
      wp[p] = wp[p] + 1'b1;
      seq   = seq + 1'b1;
    end
  endtask
  task automatic wait_done();
    for (int n = 0; n < 200 && (exp_q.size() != 0 || bus.busy); n++) @(negedge clk);
    chk("done", 32'(exp_q.size() != 0 || bus.busy), 0);
  endtask
  task automatic wait_reads(input int want);
    cnt = 0;
    for (int n = 0; n < 50 && cnt < want; n++) begin
      @(negedge clk);
      if (|bus.fifo_rd) cnt++;
    end
    chk("reads_seen", 32'(cnt), 32'(want));
  endtask
  always @(posedge clk)
    for (int i = 0; i < N_IN; i++)
      if (bus.fifo_rd[i]) begin
        bus.fifo_data[i*DW +: DW] <= mem[i][rp[i]];
        rp[i] <= rp[i] + 1'b1;
      end
  always_comb
    for (int i = 0; i < N_IN; i++) bus.req[i] = en[i] && (wp[i] != rp[i]);
  always @(negedge clk)
    if (rst_n) begin
      chk("rd_onehot", 32'($onehot0(bus.fifo_rd)), 1);
      chk("grant_onehot", 32'($onehot0(bus.grant)), 1);
      if (sb_en) begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) chk("unexpected_flit", 32'(bus.out_data), 32'hdead_beef);
          else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e.d));
            chk("out_grant", 32'(bus.grant), 32'(e.g));
          end
        end else chk("idle_data", 32'(bus.out_data), 0);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < N_IN; i++) begin
      rp[i] = '0;
      wp[i] = '0;
    end
    bus.fifo_data = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // all four request at once: 0,1,2,3 then port 0 again
    load(0, 1); load(1, 1); load(2, 1); load(3, 1); load(0, 1);
    en = 4'b1111;
    wait_done();
    en = '0;
    // lone requester on port 2, packet timing
    load(2, 1);
    en = 4'b0100;
    for (int n = 0; n < 20 && bus.grant == '0; n++) @(negedge clk);
    chk("single_grant", 32'(bus.grant), 32'h4);
    nb = 0;
    nr = 0;
    while (bus.busy && nb < 20) begin
      if (bus.fifo_rd == 4'b0100) nr++;
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(nb), 32'(PKT_LEN + 1));
    chk("rd_cycles", 32'(nr), 32'(PKT_LEN));
    wait_done();
    en = '0;
    // pointer now 3: port 3 before port 0
    load(3, 1); load(0, 1);
    en = 4'b1001;
    wait_done();
    en = '0;
    // backpressure after second read on port 1
    load(1, 1);
    en = 4'b0010;
    wait_reads(2);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_rd", 32'(bus.fifo_rd), 0);
      chk("bp_grant", 32'(bus.grant), 32'h2);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done();
    en = '0;
    // source underrun on port 2 after the first flit
    load(2, 1);
    en = 4'b0100;
    wait_reads(1);
    @(posedge clk);
    #1 en[2] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("ur_rd", 32'(bus.fifo_rd), 0);
      chk("ur_grant", 32'(bus.grant), 32'h4);
    end
    @(posedge clk);
    #1 en[2] = 1'b1;
    wait_done();
    en = '0;
    // reset in the middle of a port 0 packet
    sb_en = 1'b0;
    load(0, 0);
    en = 4'b0001;
    wait_reads(2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", 32'(bus.fifo_rd), 0);
    chk("mid_rst_grant", 32'(bus.grant), 0);
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_data", 32'(bus.out_data), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    en = '0;
    wp[0] = rp[0];
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb_en = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 0);
    // pointer back at 0: port 1 wins over port 3
    load(1, 1); load(3, 1);
    en = 4'b1010;
    wait_done();
    en = '0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
